// File: rtl/mc_control_unit.sv
// mc_control_unit
// Multi-cycle MIPS control FSM. It sequences each instruction through
// fetch / decode / execute / memory / writeback. The memory port uses a
// req/ack handshake with a bounded wait. A timeout parks the FSM in a sticky
// FAULT state. An unsupported opcode raises a one-cycle `illegal` pulse in
// DECODE and is then retired as a NOP.
//
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101)
// into BRANCH with branch_ne=1. Without it, 000101 is illegal and branch_ne
// is tied to 0.
//
// Parameters
//   MAX_WAIT : un-acknowledged cycles tolerated after a request's first cycle
//   WAIT_W   : wait counter width, 2**WAIT_W > MAX_WAIT
// Ports
//   clk, rst_n         : clock (rising edge), async active-low reset
//   opcode[5:0]        : IR[31:26], valid from DECODE onward
//   mem_ack            : memory completes the current request this cycle
//   mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
//   pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
//   arith              : datapath controls (Moore on state/op_q, plus mem_ack)
//   illegal            : unsupported opcode pulse (DECODE)
//   fault              : memory timeout, sticky until reset
//   state[3:0]         : current state, debug
module mc_control_unit #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       arith,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        WB_R   = 4'd4,
        EXEC_I = 4'd5,
        WB_I   = 4'd6,
        ADDR   = 4'd7,
        MEM_RD = 4'd8,
        WB_MEM = 4'd9,
        MEM_WR = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    state_t            curState, nxtState;
    logic [5:0]        opQ;
    logic [WAIT_W-1:0] waitCnt;
    logic              inMem;
    logic              waitExpired;

    assign inMem       = (curState == FETCH) || (curState == MEM_RD) || (curState == MEM_WR);
    assign waitExpired = (waitCnt == WAIT_W'(MAX_WAIT));
    assign state       = curState;

    // The counter counts only while a request is stalled. Any other cycle
    // (an ack, a non-memory state, or the timeout itself) returns it to 0.
    // That zero is what every memory state sees on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= IDLE;
            opQ      <= '0;
            waitCnt  <= '0;
        end else begin
            curState <= nxtState;
            if (curState == DECODE)
                opQ <= opcode;
            if (inMem && !mem_ack && !waitExpired)
                waitCnt <= waitCnt + WAIT_W'(1);
            else
                waitCnt <= '0;
        end
    end

    always_comb begin
        nxtState      = curState;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        arith         = 1'b0;
        illegal       = 1'b0;
        fault         = 1'b0;

        case (curState)
            IDLE: nxtState = FETCH;

            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;             // PC + 4
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxtState = DECODE;
                end else if (waitExpired) begin
                    nxtState = FAULT;
                end
            end

            DECODE: begin
                alu_src_b = 2'b11;             // speculative branch target
                case (opcode)
                    OP_RTYPE:         nxtState = EXEC_R;
                    OP_ADDI, OP_ANDI: nxtState = EXEC_I;
                    OP_LW, OP_SW:     nxtState = ADDR;
                    OP_BEQ:           nxtState = BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:           nxtState = BRANCH;
`endif
                    OP_JAL:           nxtState = JUMP;
                    default: begin
                        illegal  = 1'b1;
                        nxtState = FETCH;
                    end
                endcase
            end

            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b100;
                nxtState  = WB_R;
            end

            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                nxtState  = FETCH;
            end

            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opQ == OP_ANDI) begin
                    alu_op = 3'b011;
                end else begin
                    arith  = 1'b1;
                end
                nxtState  = WB_I;
            end

            WB_I: begin
                reg_write = 1'b1;
                nxtState  = FETCH;
            end

            ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                arith     = 1'b1;
                nxtState  = (opQ == OP_LW) ? MEM_RD : MEM_WR;
            end

            MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack)          nxtState = WB_MEM;
                else if (waitExpired) nxtState = FAULT;
            end

            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                nxtState   = FETCH;
            end

            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack)          nxtState = FETCH;
                else if (waitExpired) nxtState = FAULT;
            end

            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
`ifdef MC_CTRL_BNE_EN
                branch_ne     = (opQ == OP_BNE);
`else
                branch_ne     = 1'b0;
`endif
                nxtState      = FETCH;
            end

            JUMP: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;             // link: PC+4 into $31
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                nxtState   = FETCH;
            end

            FAULT: fault = 1'b1;               // terminal until reset

            default: nxtState = IDLE;          // unused encodings recover
        endcase
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS control FSM. It replaces the single-cycle opcode decoder, sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-memory multi-cycle datapath. It adds a memory request/acknowledge handshake with a bounded wait timeout, a sticky fault state, and an illegal-opcode report. All control outputs are a Moore decode of the current state and the registered opcode.

## Interface
- `MAX_WAIT`, default 15: maximum number of un-acknowledged cycles allowed after the first cycle of a memory request.
- `WAIT_W`, default 4: width of the wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]. Valid from DECODE onward.
- `mem_ack` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, qualified by `mem_req`.
- `i_or_d` out 1: 0 = PC address, 1 = ALUOut address.
- `ir_write` out 1: load IR.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load when the branch condition holds.
- `branch_ne` out 1: 1 = branch condition is !zero, 0 = branch condition is zero.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 2: 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op` out 3: 000 = add, 001 = sub, 011 = and, 100 = funct.
- `arith` out 1: sign-extend/overflow select. Never X.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `fault` out 1: memory timeout. Sticky until reset.
- `state` out 4: current state, for debug.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, ADDR=7, MEM_RD=8, WB_MEM=9, MEM_WR=10, BRANCH=11, JUMP=12, FAULT=15. Every undriven output is 0 in every state.
- IDLE: all outputs 0. Goes to FETCH on the next clock.
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_b`=01, `alu_op`=000.
  - On the cycle with `mem_ack`=1, also `ir_write`=1, `pc_write`=1, `pc_src`=00. Next state: DECODE.
- DECODE: `alu_src_b`=11, `alu_op`=000. Registers `opcode` into `op_q`. Next state by `opcode`:
  - 000000 → EXEC_R
  - 001000 or 001100 → EXEC_I
  - 100011 or 101011 → ADDR
  - 000100 → BRANCH
  - 000011 → JUMP
  - any other opcode → `illegal`=1 this cycle, then FETCH (treated as a NOP).
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=100. Next: WB_R.
- WB_R: `reg_write`=1, `reg_dst`=01. Next: FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10.
  - addi: `alu_op`=000, `arith`=1.
  - andi: `alu_op`=011, `arith`=0.
  - Next: WB_I.
- WB_I: `reg_write`=1, `reg_dst`=00. Next: FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000, `arith`=1. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_req`=1, `i_or_d`=1. On ack, next: WB_MEM.
- WB_MEM: `reg_write`=1, `mem_to_reg`=01. Next: FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `i_or_d`=1. On ack, next: FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_src`=01. Next: FETCH.
- JUMP: `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `pc_write`=1, `pc_src`=10. Next: FETCH.
- Wait counter (applies in FETCH, MEM_RD and MEM_WR):
  - Cleared to 0 on entry to each of these states.
  - Increments on each cycle with `mem_ack`=0.
  - `mem_ack`=0 while the counter equals `MAX_WAIT` → FAULT. So `mem_req` is asserted for at most MAX_WAIT+1 cycles.
  - With `MAX_WAIT`=0, the acknowledge must arrive in the first cycle.
- FAULT: `fault`=1, all other outputs 0, `mem_ack` ignored. Exits only through reset.
- `mem_ack` is ignored in every state that does not assert `mem_req`.

## Timing
- `rst_n` low: state is forced to IDLE immediately (asynchronously); counter, `op_q` and `fault` are cleared; every output reads 0. This holds mid-instruction as well; an in-flight memory request is dropped.
- First FETCH occurs on the second rising edge after `rst_n` deasserts.
- Cycles per instruction, with zero wait states:
  - R-type, addi/andi: 4
  - lw: 5
  - sw: 4
  - beq, jal: 3
  - illegal opcode: 2
- Each wait cycle adds 1.
- Outputs are combinational from `state`, `op_q` and `mem_ack`; there is no output register.

## Configuration
- `MC_CTRL_BNE_EN` defined:
  - Opcode 000101 decodes to BRANCH, with `branch_ne`=1 for that instruction.
  - For beq, `branch_ne`=0.
- `MC_CTRL_BNE_EN` undefined:
  - Opcode 000101 is illegal.
  - `branch_ne` is tied to 0.

## Test plan
- Reset release, `mem_ack` tied to 1, add (opcode 000000) → states 0,1,2,3,4,1. `reg_write`=1 with `reg_dst`=01 only in WB_R.
- lw (100011) with FETCH ack after 2 wait cycles and MEM_RD ack immediately → FETCH lasts 3 cycles; `i_or_d`=1 only in MEM_RD; WB_MEM drives `mem_to_reg`=01.
- `MAX_WAIT`=3, FETCH with no ack → `mem_req` high exactly 4 cycles, then `state`=15 and `fault`=1, held for 20 cycles until `rst_n` pulses low.
- Opcode 111111 → `illegal` high exactly 1 cycle in DECODE; next state is FETCH; `reg_write` and `pc_write_cond` are never asserted.
- Opcode 000101 → with `MC_CTRL_BNE_EN`: BRANCH, `branch_ne`=1, `pc_write_cond`=1. Without it: `illegal`=1.
- `rst_n` asserted during MEM_WR with `mem_we`=1 → `mem_req` and `mem_we` drop to 0 in the same cycle; `state`=0.
